// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI frame width, FSM states and synchronizer output modes
package spi_pkg;
  localparam int SPI_FRAME_W = 12;
  localparam int SYNC_LEVEL = 0;
  localparam int SYNC_RISE = 1;
  localparam int SYNC_FALL = 2;
  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, TAIL} spi_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-stage pin synchronizer emitting the level or a rise/fall pulse
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MODE = SYNC_LEVEL,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] chain;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chain <= {SYNC_STAGES{RST_VAL}};
    else chain <= {chain[SYNC_STAGES-2:0], d};
  generate
    if (MODE == SYNC_LEVEL) begin : g_level
      assign q = chain[SYNC_STAGES-1];
    end else begin : g_edge
      logic prev;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) prev <= RST_VAL;
        else prev <= chain[SYNC_STAGES-1];
      assign q = (MODE == SYNC_RISE) ? chain[SYNC_STAGES-1] & ~prev : ~chain[SYNC_STAGES-1] & prev;
    end
  endgenerate
endmodule

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: oversampled SPI frame receiver with a one-entry valid/ready output buffer
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_FRAME_W,
  parameter int SYNC_STAGES = 2,
  parameter int LEAD_SKIP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);
  localparam int BW = $clog2(DATA_W + 1);
  localparam int SKW = $clog2(LEAD_SKIP + 2);
  spi_state_e state;
  logic cs_s, mosi_s, sclk_fall, done;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0] bit_cnt;
  logic [SKW-1:0] skip_cnt;
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .MODE(SYNC_LEVEL), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .d(cs), .q(cs_s)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .MODE(SYNC_FALL), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .MODE(SYNC_LEVEL), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      skip_cnt <= '0;
      done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      done <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          skip_cnt <= '0;
          if (!cs_s) state <= (LEAD_SKIP == 0) ? SHIFT : SKIP;
        end
        SKIP:
          if (cs_s) begin
            state <= IDLE;
            frame_err <= 1'b1;
          end else if (sclk_fall) begin
            skip_cnt <= skip_cnt + SKW'(1);
            if (skip_cnt == SKW'(LEAD_SKIP - 1)) state <= SHIFT;
          end
        SHIFT:
          if (cs_s) begin
            state <= IDLE;
            frame_err <= 1'b1;
          end else if (sclk_fall) begin
            shreg <= {shreg[DATA_W-2:0], mosi_s};
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == BW'(DATA_W - 1)) begin
              state <= TAIL;
              done <= 1'b1;
            end
          end
        TAIL: if (cs_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dout <= '0;
      dout_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= done & dout_valid & ~dout_ready;
      if (done && (!dout_valid || dout_ready)) begin
        dout <= shreg;
        dout_valid <= 1'b1;
      end else if (dout_ready) dout_valid <= 1'b0;
    end
  assign busy = state != IDLE;
endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: randomized SPI peer driving spi_slave_rx, scored against a frame-level model
module tb_spi_slave_rx;
  import spi_pkg::*;
  localparam int W = SPI_FRAME_W;
  logic clk = 0, rst_n = 0, cs = 1, sclk = 0, mosi = 0, dout_ready = 0;
  logic [W-1:0] dout;
  logic dout_valid, frame_err, overrun, busy;
  int n_cmp = 0, n_fail = 0;
  int exp_err = 0, exp_ovr = 0, obs_err = 0, obs_ovr = 0;
  logic [W-1:0] exp_q[$];
  logic prev_err = 0, prev_ovr = 0, held = 0;
  logic [W-1:0] held_w = '0;

  spi_slave_rx dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .sclk(sclk), .mosi(mosi),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (frame_err) begin
        obs_err++;
        check("frame_err one cycle", prev_err, 0);
      end
      if (overrun) begin
        obs_ovr++;
        check("overrun one cycle", prev_ovr, 0);
      end
      if (held && dout_valid) check("dout stable while held", dout, held_w);
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected word: got %0h, want none", dout);
        end else check("dout word", dout, exp_q.pop_front());
      end
      held = dout_valid && !dout_ready;
      held_w = dout;
      prev_err = frame_err;
      prev_ovr = overrun;
    end else begin
      held = 0;
      prev_err = 0;
      prev_ovr = 0;
    end
  end

  task automatic sclk_period(input logic b, input int hp);
    sclk = 1;
    mosi = b;
    repeat (hp) @(negedge clk);
    sclk = 0;
    repeat (hp) @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] w, input int nbits, input int extra, input int hp,
                      input bit hit, input bit drop);
    if (nbits < W) exp_err++;
    else if (drop) exp_ovr++;
    else exp_q.push_back(w);
    cs = 0;
    repeat (hp) @(negedge clk);
    sclk_period(1'($urandom), hp);
    for (int i = 0; i < nbits; i++) begin
      if (hit && i == nbits - 1) begin
        sclk = 1;
        mosi = w[W-1-i];
        repeat (hp) @(negedge clk);
        sclk = 0;
        repeat (3) @(negedge clk);
        dout_ready = 1;
        @(negedge clk);
        dout_ready = 0;
        #1;
        check("coincident valid", dout_valid, 1);
        check("coincident dout", dout, w);
        repeat (hp - 5) @(negedge clk);
      end else sclk_period(w[W-1-i], hp);
    end
    if (nbits == W) repeat (1 + extra) sclk_period(1'($urandom), hp);
    cs = 1;
    sclk = 0;
    repeat (2 * hp) @(negedge clk);
  endtask

  task automatic sync_counts(input string name);
    repeat (4) @(negedge clk);
    #2;
    check({name, " frame_err count"}, obs_err, exp_err);
    check({name, " overrun count"}, obs_ovr, exp_ovr);
  endtask

  initial begin
    logic [W-1:0] w;
    int nb;
    repeat (3) @(negedge clk);
    #1;
    check("reset dout", dout, 0);
    check("reset dout_valid", dout_valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    check("reset busy", busy, 0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    dout_ready = 1;
    send(12'hA5C, W, 0, 11, 0, 0);
    sync_counts("single");
    dout_ready = 0;
    send(12'hFFF, W, 0, 11, 0, 0);
    send(12'h001, W, 0, 11, 0, 1);
    #1;
    check("retained dout", dout, 12'hFFF);
    check("retained valid", dout_valid, 1);
    sync_counts("overrun");
    @(negedge clk);
    dout_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    check("valid drops after ready", dout_valid, 0);
    send(12'h3C3, 5, 0, 11, 0, 0);
    #1;
    check("no word after abort", dout_valid, 0);
    sync_counts("abort");
    send(12'h123, W, 0, 11, 0, 0);
    send(12'h800, W, 2, 11, 0, 0);
    sync_counts("tail");
    cs = 0;
    repeat (11) @(negedge clk);
    sclk_period(1'b0, 11);
    for (int i = 0; i < 4; i++) sclk_period(1'b1, 11);
    #1;
    check("busy mid-shift", busy, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("in reset dout", dout, 0);
    check("in reset dout_valid", dout_valid, 0);
    check("in reset frame_err", frame_err, 0);
    check("in reset overrun", overrun, 0);
    check("in reset busy", busy, 0);
    cs = 1;
    repeat (5) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    #1;
    check("after reset busy", busy, 0);
    send(12'h555, W, 0, 11, 0, 0);
    sync_counts("reset");
    dout_ready = 0;
    send(12'h0AA, W, 0, 11, 0, 0);
    send(12'h155, W, 0, 11, 1, 0);
    dout_ready = 1;
    sync_counts("coincident");
    for (int k = 0; k < 14; k++) begin
      w = W'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : W;
      send(w, nb, int'($urandom_range(0, 2)), int'($urandom_range(6, 14)), 0, 0);
    end
    for (int t = 0; t < 1000 && exp_q.size() != 0; t++) @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    sync_counts("final");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
